// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter: merges ALU results with a queued LSU result stream
// into one registered write per cycle and tracks pending writes per register.
module regfile_wb_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          iss_valid,
    input  logic [$clog2(DEPTH)-1:0]      iss_rd,
    input  logic                          alu_valid,
    input  logic [$clog2(DEPTH)-1:0]      alu_rd,
    input  logic [WIDTH-1:0]              alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [$clog2(DEPTH)-1:0]      mem_rd,
    input  logic [WIDTH-1:0]              mem_data,
    output logic                          mem_ready,
    output logic                          REGWRITE,
    output logic [$clog2(DEPTH)-1:0]      ADR_WR_REG,
    output logic [WIDTH-1:0]              WR_DATA,
    output logic [DEPTH-1:0]              busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [AW-1:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    logic             regwrite_q;
    logic [AW-1:0]    adr_q;
    logic [WIDTH-1:0] data_q;
    logic [DEPTH-1:0] busy_q, busy_d;

    logic             full, empty, push, pop, sel_valid;
    logic [AW-1:0]    sel_rd;
    logic [WIDTH-1:0] sel_data;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign mem_ready = !full;
    assign alu_ready = !full;
    assign push      = mem_valid && !full;

    // A full queue preempts the ALU so LSU results can always drain.
    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = adr_q;
        sel_data  = data_q;
        if (full || (!alu_valid && !empty)) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel_rd    = fifo_rd_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
        end else if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    // Set is applied after clear so a same-edge reissue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (sel_valid && sel_rd != '0)
            busy_d[sel_rd] = 1'b0;
        if (iss_valid && iss_rd != '0)
            busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= mem_rd;
            fifo_data_q[wr_ptr_q] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            adr_q      <= '0;
            data_q     <= '0;
            busy_q     <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            regwrite_q <= sel_valid && (sel_rd != '0);
            if (sel_valid) begin
                adr_q  <= sel_rd;
                data_q <= sel_data;
            end
            busy_q <= busy_d;
        end
    end

    assign REGWRITE   = regwrite_q;
    assign ADR_WR_REG = adr_q;
    assign WR_DATA    = data_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a cycle-level reference model and
// a queue of expected writeback values.
module tb_regfile_wb_arbiter;
    logic        clk, rst;
    logic        iss_valid, alu_valid, mem_valid;
    logic [4:0]  iss_rd, alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, REGWRITE;
    logic [4:0]  ADR_WR_REG;
    logic [31:0] WR_DATA, busy;
    logic [2:0]  fifo_count;

    regfile_wb_arbiter #(.WIDTH(32), .DEPTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .REGWRITE(REGWRITE), .ADR_WR_REG(ADR_WR_REG), .WR_DATA(WR_DATA),
        .busy(busy), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [4:0]  mq_rd[$];
    logic [31:0] mq_dat[$];
    logic [37:0] exp_q[$];
    logic [31:0] bm;
    logic [4:0]  last_adr;
    logic [31:0] last_data;
    logic        collect;
    logic [4:0]  seen[$];
    int          peak;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iss_valid = 0; iss_rd = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        mq_rd.delete(); mq_dat.delete(); exp_q.delete();
        bm = '0; last_adr = '0; last_data = '0;
        chk("rst_regwrite", REGWRITE, 0);
        chk("rst_adr", ADR_WR_REG, 0);
        chk("rst_data", WR_DATA, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
    endtask

    task automatic step(input logic iv, input logic [4:0] ird,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        output logic a_acc, output logic m_acc);
        logic        full, sel;
        logic [4:0]  srd;
        logic [31:0] sdat, b;
        logic [37:0] e;
        iss_valid = iv; iss_rd = ird;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        full = (mq_rd.size() == 4);
        chk("mem_ready", mem_ready, !full);
        chk("alu_ready", alu_ready, !full);
        m_acc = mv && !full;
        a_acc = av && !full;
        sel = 1'b0; srd = last_adr; sdat = last_data;
        if (full || (!av && mq_rd.size() != 0)) begin
            sel = 1'b1; srd = mq_rd.pop_front(); sdat = mq_dat.pop_front();
        end else if (av) begin
            sel = 1'b1; srd = ard; sdat = ad;
        end
        if (m_acc) begin
            mq_rd.push_back(mrd); mq_dat.push_back(md);
        end
        exp_q.push_back({sel && srd != 0, srd, sdat});
        last_adr = srd; last_data = sdat;
        b = bm;
        if (sel && srd != 0) b[srd] = 1'b0;
        if (iv && ird != 0) b[ird] = 1'b1;
        bm = b;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("regwrite", REGWRITE, e[37]);
        chk("adr_wr_reg", ADR_WR_REG, e[36:32]);
        chk("wr_data", WR_DATA, e[31:0]);
        chk("busy", busy, bm);
        chk("fifo_count", fifo_count, mq_rd.size());
        if (fifo_count > peak) peak = fifo_count;
        if (collect && REGWRITE === 1'b1 && ADR_WR_REG >= 1 && ADR_WR_REG <= 6)
            seen.push_back(ADR_WR_REG);
    endtask

    initial begin
        logic aa, ma;
        int idx, cyc;
        collect = 0; peak = 0;
        do_reset();

        // ALU single write with scoreboard set then clear
        step(1, 5, 0, 0, 0, 0, 0, 0, aa, ma);
        chk("busy5_set", busy[5], 1);
        step(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, aa, ma);
        chk("alu_regwrite", REGWRITE, 1);
        chk("alu_adr", ADR_WR_REG, 5);
        chk("alu_data", WR_DATA, 32'hDEADBEEF);
        chk("busy5_clr", busy[5], 0);

        // x0 write and issue
        step(1, 0, 1, 0, 32'h1234, 0, 0, 0, aa, ma);
        chk("x0_accept", aa, 1);
        chk("x0_regwrite", REGWRITE, 0);
        chk("x0_busy0", busy[0], 0);

        // FIFO fill with the ALU held valid on rd=7
        idx = 1; cyc = 0; collect = 1; seen.delete(); peak = 0;
        while (idx <= 6 && cyc < 40) begin
            step(0, 0, 1, 7, 32'hA000_0000 + cyc, 1, idx[4:0], 32'hB000_0000 + idx, aa, ma);
            if (ma) idx++;
            cyc++;
        end
        chk("fill_done", idx, 7);
        chk("fill_peak", peak, 4);
        while (mq_rd.size() != 0 && cyc < 60) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
            cyc++;
        end
        chk("fill_drained", mq_rd.size(), 0);
        collect = 0;
        chk("lsu_order_len", seen.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("lsu_order", (i < seen.size()) ? seen[i] : 5'd0, i + 1);

        // Two entries queued, then steady push+pop across pointer wrap
        step(0, 0, 1, 0, 32'h0, 1, 12, 32'hC000_000C, aa, ma);
        step(0, 0, 1, 0, 32'h0, 1, 13, 32'hC000_000D, aa, ma);
        chk("pp_prefill", fifo_count, 2);
        for (int k = 14; k < 24; k++) begin
            step(0, 0, 0, 0, 0, 1, k[4:0], 32'hC000_0000 + k, aa, ma);
            chk("pp_count", fifo_count, 2);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
        step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
        chk("pp_last_adr", ADR_WR_REG, 23);

        // Set/clear collision on rd=9
        step(1, 9, 0, 0, 0, 0, 0, 0, aa, ma);
        step(1, 9, 1, 9, 32'h9999_0009, 0, 0, 0, aa, ma);
        chk("coll_regwrite", REGWRITE, 1);
        chk("coll_busy9", busy[9], 1);

        // Reset with three LSU entries pending and busy=0x0F0E
        step(1, 1,  1, 0, 0, 1, 20, 32'hE000_0014, aa, ma);
        step(1, 2,  1, 0, 0, 1, 21, 32'hE000_0015, aa, ma);
        step(1, 3,  1, 0, 0, 1, 22, 32'hE000_0016, aa, ma);
        step(1, 8,  1, 0, 0, 0, 0, 0, aa, ma);
        step(1, 10, 1, 0, 0, 0, 0, 0, aa, ma);
        step(1, 11, 1, 0, 0, 0, 0, 0, aa, ma);
        chk("pre_rst_busy", busy, 32'h0000_0F0E);
        chk("pre_rst_count", fifo_count, 3);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, aa, ma);
            chk("post_rst_no_write", REGWRITE, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
